uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Receive-side UART: deserializes an 8N1 asynchronous serial line into bytes.
//  Runs in the same clock domain as uart_transmitter, with the same baud timing.
//  Consumer-facing hold/acknowledge handshake, plus framing-error and overrun flags.
//  Sits between the board rx pin and byte-level consumers (echo, command decoders).
// PARAMETERS
//  ClocksPerBaud  `DEFAULT_CLOCKS_PER_BAUD  clk cycles per bit; must be >= 4.
//  SyncStages     2                         rx_in synchronizer depth; must be >= 2.
// PORTS
//  clk                input   1  system clock; sole clock.
//  rst_n              input   1  asynchronous, active-low reset.
//  rx_in              input   1  async serial line; idle high.
//  rx_byte_done       input   1  consumer ack; pulse to retire the held byte.
//  rx_byte_out        output  8  last received byte, LSB first on the wire.
//  rx_byte_valid_out  output  1  high while rx_byte_out holds an unacknowledged byte.
//  rx_error_out       output  1  framing error: stop bit sampled low.
//  rx_overrun_out     output  1  an unacknowledged byte was overwritten.
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All outputs 0, state Idle, counters 0.
//   - Synchronizer flops reset to 1 (idle line).
//  Sampling:
//   - rx_s is rx_in after SyncStages flops.
//   - Bit counter: $clog2(ClocksPerBaud) bits; counts 0..ClocksPerBaud-1, then wraps to 0.
//  States:
//   Idle:
//    - rx_s==0 -> StartBit, counter cleared.
//   StartBit:
//    - At counter==ClocksPerBaud/2-1, sample rx_s.
//    - Sample 1 -> false start, back to Idle; no flags change.
//    - Sample 0 -> DataBits, counter and bit index cleared; all later samples are whole-bit spaced.
//   DataBits:
//    - At each counter==ClocksPerBaud-1, shift rx_s into shift[7] (right shift).
//    - After the 8th sample -> StopBit.
//   StopBit:
//    - At counter==ClocksPerBaud-1, sample rx_s.
//    - Sample 1 -> deliver the byte, go to Idle.
//    - Sample 0 -> set rx_error_out, go to Break.
//   Break:
//    - Wait for rx_s==1, then Idle. No byte is delivered.
//   Any illegal state encoding -> Idle.
//  Delivery, in the cycle after the stop sample:
//   - rx_byte_out <= shift; rx_byte_valid_out <= 1.
//   - If valid was 1 and rx_byte_done is not high that cycle: rx_overrun_out <= 1. The new byte overwrites the old.
//   - rx_byte_done in the same cycle as delivery: new byte wins, valid stays 1, no overrun.
//  Acknowledge:
//   - rx_byte_done while valid (no delivery) -> valid and overrun clear next cycle. rx_byte_out holds its value.
//   - rx_byte_done while valid==0 is ignored.
//  rx_error_out:
//   - Sticky; cleared when the next StartBit sample confirms a start, or by reset.
//  Latency:
//   - valid rises exactly ClocksPerBaud/2 + 9*ClocksPerBaud + 1 cycles after the first Idle cycle with rx_s==0.
//  Reset mid-frame:
//   - Frame is discarded, no flags set.
//   - Line activity continuing into reset release is resynchronized: the next low seen in Idle starts a frame.
// STRUCTURE
//  Shared include uart_defs.vh: `DEFAULT_CLOCKS_PER_BAUD and the receiver state localparams.
//   - States: Idle=0, StartBit=1, DataBits=2, StopBit=3, Break=4; 3 state bits.
//  Sub-module uart_rx_sync:
//   - Parameterized SyncStages flop chain, reset value 1, async active-low reset.
//  Remainder in this module:
//   - One state-register always block and combinational next-state/output blocks.
// TESTING (bench ClocksPerBaud=4, SyncStages=2, drive rx_in from a bit-accurate model)
//  1. Frame 0x41, stop=1, rx_byte_done held 0
//     -> valid=1 after the exact latency, rx_byte_out=0x41, error=0, overrun=0.
//     -> Pulse rx_byte_done: valid=0 next cycle, byte held.
//  2. rx_in low for 1 clk, then high (shorter than half a bit)
//     -> false start, state back to Idle, no valid, no flags.
//  3. Frame 0x55 with stop=0, then line high 2 bits, then frame 0x42
//     -> error=1, no delivery for 0x55.
//     -> error clears at 0x42 start; valid with 0x42.
//  4. Frames 0x42 then 0x43 back-to-back, no ack
//     -> rx_byte_out=0x43, valid=1, overrun=1.
//     -> Ack clears valid and overrun.
//  5. rx_byte_done pulsed in the exact delivery cycle of a second byte 0x44
//     -> valid stays 1, rx_byte_out=0x44, overrun=0.
//  6. rst_n low during data bit 3 of frame 0x43
//     -> all outputs 0 immediately.
//     -> After release and line idle, frame 0x43 is received correctly.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART receiver constants and state encoding
package uart_receiver_pkg;

  localparam int DEFAULT_CLOCKS_PER_BAUD = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-stage synchronizer for the async rx line, resets to idle-high
module uart_rx_sync #(
  parameter int Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[Stages-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with hold/ack handshake, framing-error and overrun flags
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int ClocksPerBaud = DEFAULT_CLOCKS_PER_BAUD,
  parameter int SyncStages    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       rx_byte_done,
  output logic [7:0] rx_byte_out,
  output logic       rx_byte_valid_out,
  output logic       rx_error_out,
  output logic       rx_overrun_out
);

  localparam int CntW = $clog2(ClocksPerBaud);
  localparam logic [CntW-1:0] CntLast = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClocksPerBaud / 2 - 1);

  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;
  logic            overrun_q, overrun_d;
  logic            deliver;

  uart_rx_sync #(.Stages(SyncStages)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    error_d   = error_q;
    overrun_d = overrun_q;
    deliver   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Mid-start-bit check; from here on every sample is one whole bit later.
        if (cnt_q == CntHalf) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
            error_d   = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CntLast) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == CntLast) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // An ack coinciding with delivery retires the old byte, so no overrun.
    if (deliver) begin
      byte_d  = shift_d;
      valid_d = 1'b1;
      if (rx_byte_done) begin
        overrun_d = 1'b0;
      end else if (valid_q) begin
        overrun_d = 1'b1;
      end
    end else if (rx_byte_done && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign rx_byte_out       = byte_q;
  assign rx_byte_valid_out = valid_q;
  assign rx_error_out      = error_q;
  assign rx_overrun_out    = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver with directed serial frames
module tb_uart_receiver;

  localparam int CPB = 4;
  localparam int LAT = CPB / 2 + 9 * CPB + 1;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_byte_done = 1'b0;
  logic [7:0] rx_byte_out;
  logic       valid;
  logic       err;
  logic       ovr;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  uart_receiver #(.ClocksPerBaud(CPB), .SyncStages(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_in             (rx_in),
    .rx_byte_done      (rx_byte_done),
    .rx_byte_out       (rx_byte_out),
    .rx_byte_valid_out (valid),
    .rx_error_out      (err),
    .rx_overrun_out    (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovr  = o;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; each bit is held for CPB clocks, line left idle-high.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_byte_done = 1'b1;
    @(negedge clk);
    rx_byte_done = 1'b0;
  endtask

  // Monitor: a delivery is valid rising, or a new byte appearing while valid stays high.
  initial begin
    exp_t       e;
    logic       prev_valid;
    logic [7:0] prev_byte;
    prev_valid = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (valid && (!prev_valid || rx_byte_out !== prev_byte)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_delivery: got byte %h, expected no delivery", rx_byte_out);
          end else begin
            e = exp_q.pop_front();
            check("sb_byte", rx_byte_out, e.data);
            check("sb_overrun", {7'd0, ovr}, {7'd0, e.ovr});
            check("sb_error", {7'd0, err}, 8'd0);
          end
        end
        prev_valid = valid;
        prev_byte  = rx_byte_out;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_byte", rx_byte_out, 8'h00);
    check("reset_valid", {7'd0, valid}, 8'd0);
    check("reset_error", {7'd0, err}, 8'd0);
    check("reset_overrun", {7'd0, ovr}, 8'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // 1: single frame, exact latency, then ack
    push_exp(8'h41, 1'b0);
    fork
      send_frame(8'h41, 1'b1);
      begin
        repeat (LAT + 1) @(negedge clk);
        check("t1_valid_before_latency", {7'd0, valid}, 8'd0);
        @(negedge clk);
        check("t1_valid_at_latency", {7'd0, valid}, 8'd1);
      end
    join
    ack_pulse();
    check("t1_valid_after_ack", {7'd0, valid}, 8'd0);
    check("t1_byte_held", rx_byte_out, 8'h41);

    // 2: glitch shorter than half a bit
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("t2_valid", {7'd0, valid}, 8'd0);
    check("t2_error", {7'd0, err}, 8'd0);
    check("t2_overrun", {7'd0, ovr}, 8'd0);

    // 3: framing error, break, then a good frame clears the error at start confirmation
    send_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("t3_error_set", {7'd0, err}, 8'd1);
    check("t3_no_delivery", {7'd0, valid}, 8'd0);
    push_exp(8'h42, 1'b0);
    fork
      send_frame(8'h42, 1'b1);
      begin
        repeat (4) @(negedge clk);
        check("t3_error_before_confirm", {7'd0, err}, 8'd1);
        @(negedge clk);
        check("t3_error_cleared", {7'd0, err}, 8'd0);
      end
    join
    @(negedge clk);
    check("t3_byte", rx_byte_out, 8'h42);
    ack_pulse();
    check("t3_valid_after_ack", {7'd0, valid}, 8'd0);

    // 4: back-to-back frames without ack overrun
    push_exp(8'h42, 1'b0);
    push_exp(8'h43, 1'b1);
    send_frame(8'h42, 1'b1);
    send_frame(8'h43, 1'b1);
    @(negedge clk);
    check("t4_byte", rx_byte_out, 8'h43);
    check("t4_valid", {7'd0, valid}, 8'd1);
    check("t4_overrun", {7'd0, ovr}, 8'd1);
    ack_pulse();
    check("t4_valid_after_ack", {7'd0, valid}, 8'd0);
    check("t4_overrun_after_ack", {7'd0, ovr}, 8'd0);
    check("t4_byte_held", rx_byte_out, 8'h43);

    // 5: ack lands in the delivery cycle of the second byte
    push_exp(8'h41, 1'b0);
    push_exp(8'h44, 1'b0);
    send_frame(8'h41, 1'b1);
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (LAT + 1) @(negedge clk);
        ack_pulse();
        check("t5_valid", {7'd0, valid}, 8'd1);
        check("t5_byte", rx_byte_out, 8'h44);
        check("t5_overrun", {7'd0, ovr}, 8'd0);
      end
    join

    // 6: reset during data bit 3, held to end of frame, then a clean frame
    fork
      send_frame(8'h43, 1'b1);
      begin
        repeat (4 * CPB + 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_reset_byte", rx_byte_out, 8'h00);
        check("t6_reset_valid", {7'd0, valid}, 8'd0);
        check("t6_reset_error", {7'd0, err}, 8'd0);
        check("t6_reset_overrun", {7'd0, ovr}, 8'd0);
      end
    join
    repeat (2 * CPB) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t6_idle_valid", {7'd0, valid}, 8'd0);
    push_exp(8'h43, 1'b0);
    send_frame(8'h43, 1'b1);
    @(negedge clk);
    check("t6_valid", {7'd0, valid}, 8'd1);
    check("t6_byte", rx_byte_out, 8'h43);

    repeat (4) @(negedge clk);
    check("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
